fetch_queue: RTL

Parametrised instruction-fetch unit with a decoupled prefetch queue. It generates sequential byte-address PCs, reads a synchronous 1-cycle-latency instruction memory, and buffers fetched {pc, instr} pairs in a FIFO. Decode consumes entries through a valid/ready handshake, and the execute stage redirects fetch on taken branches and jumps. It sits between the instruction memory and decode, replacing the single-shot enable/completed fetch with a pipelined, back-pressured front end.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch front end.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam int              C_XLEN        = 32;
    localparam int              C_INSTR_BYTES = 4;
    localparam logic [C_XLEN-1:0] C_RESET_PC  = '0;

    typedef struct packed {
        logic [C_XLEN-1:0] pc;
        logic [C_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo
// Brief    : Single-clock FIFO with occupancy count and synchronous flush.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && !flush && w_do_push)
            r_mem[r_wr_ptr] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module   : fetch_queue
// Brief    : Sequential-PC fetch unit with credit-controlled prefetch queue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int              XLEN        = 32,
    parameter  int              MEM_DEPTH   = 64,
    parameter  int              QUEUE_DEPTH = 4,
    parameter  logic [XLEN-1:0] RESET_PC    = XLEN'(C_RESET_PC),
    localparam int              AW          = $clog2(MEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [XLEN-1:0] deq_pc,
    output logic [XLEN-1:0] deq_instr
);

    localparam int            c_cw    = $clog2(QUEUE_DEPTH + 1);
    localparam logic [c_cw:0] c_depth = (c_cw + 1)'(QUEUE_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight;
    logic            r_drop;

    entry_t          w_wdata;
    entry_t          w_head;
    logic            w_full;
    logic            w_empty;
    logic [c_cw-1:0] w_count;
    logic [c_cw:0]   w_used;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc & ~XLEN'(3);
    assign w_used        = {1'b0, w_count} + (c_cw + 1)'(r_inflight);
    assign deq_valid     = rstn && !w_empty && !redirect_valid;
    assign w_pop         = deq_valid && deq_ready;
    // Credits count queued plus in-flight entries; a same-cycle pop returns one credit.
    assign w_issue       = rstn && !redirect_valid && (w_used < c_depth + (c_cw + 1)'(w_pop));
    assign w_push        = r_inflight && !r_drop;
    assign w_wdata       = '{pc: r_inflight_pc, instr: imem_rdata};

    assign imem_req  = w_issue;
    assign imem_addr = rstn ? r_fetch_pc[AW+1:2] : '0;
    assign deq_pc    = rstn ? w_head.pc    : '0;
    assign deq_instr = rstn ? w_head.instr : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_drop        <= 1'b0;
        end else if (redirect_valid) begin
            // The outstanding response belongs to the abandoned stream.
            r_fetch_pc <= w_redirect_pc;
            r_drop     <= r_inflight;
            r_inflight <= 1'b0;
        end else begin
            r_drop     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + XLEN'(C_INSTR_BYTES);
            end
        end
    end

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .wdata (w_wdata),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rstn)
            assert (!(w_push && w_full && !w_pop));
    end

endmodule

`default_nettype wire
